// File: rtl/boat_anim_sprite.sv
//==============================================================================
// Module   : boat_anim_sprite
// Brief    : Procedural animated 80x80 boat sprite. Outputs are combinational
//            from the beam position. The wake layer is built only when the
//            BOAT_WAKE_EN macro is defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module boat_anim_sprite (
  input  logic        clk,
  input  logic        rst,
  input  logic        slow_anim_tick,
  input  logic [9:0]  car_x,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  output logic [11:0] boat_pixel,
  output logic        in_boat_area
);

  localparam logic [11:0] c_GRAY  = 12'h888;
  localparam logic [11:0] c_RED   = 12'hF00;
  localparam logic [11:0] c_CYAN  = 12'h09F;
  localparam logic [11:0] c_WHITE = 12'hFFF;
  localparam logic [11:0] c_BROWN = 12'h841;
  localparam logic [9:0]  c_TOP_Y = 10'd400;

  logic [1:0] r_frame;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_frame <= 2'd0;
    else if (slow_anim_tick)
      r_frame <= r_frame + 2'd1;
  end

  // 12-bit signed keeps hCount - car_x + 40 exact, so a left-edge boat never wraps
  logic signed [11:0] w_lx;
  logic signed [11:0] w_ly;
  logic               w_in_box;
  logic [6:0]         w_x;
  logic [6:0]         w_y;

  assign w_lx     = $signed({2'b00, hCount}) - $signed({2'b00, car_x}) + 12'sd40;
  assign w_ly     = $signed({2'b00, vCount}) - $signed({2'b00, c_TOP_Y});
  assign w_in_box = (w_lx >= 12'sd0) && (w_lx <= 12'sd79) &&
                    (w_ly >= 12'sd0) && (w_ly <= 12'sd79);
  assign w_x      = w_lx[6:0];
  assign w_y      = w_ly[6:0];

  logic       w_mast;
  logic       w_flag;
  logic       w_window;
  logic       w_cabin;
  logic       w_deck;
  logic       w_hull;
  logic       w_wake;
  logic [6:0] w_flag_last;
  logic [6:0] w_r;
  logic [6:0] w_half;

  assign w_flag_last = r_frame[0] ? 7'd49 : 7'd53;
  assign w_r         = w_y - 7'd40;
  assign w_half      = w_r >> 1;

  assign w_mast   = (w_x >= 7'd38) && (w_x <= 7'd41) && (w_y <= 7'd19);
  assign w_flag   = (w_y >= 7'd2) && (w_y <= 7'd9) &&
                    (w_x >= 7'd42) && (w_x <= w_flag_last);
  assign w_window = (w_x >= 7'd30) && (w_x <= 7'd49) &&
                    (w_y >= 7'd26) && (w_y <= 7'd31);
  assign w_cabin  = (w_x >= 7'd24) && (w_x <= 7'd55) &&
                    (w_y >= 7'd20) && (w_y <= 7'd39);
  assign w_deck   = (w_y >= 7'd40) && (w_y <= 7'd43);
  assign w_hull   = (w_y >= 7'd44) && (w_y <= 7'd63) &&
                    (w_x >= w_half) && (w_x <= (7'd79 - w_half));

`ifdef BOAT_WAKE_EN
  logic [6:0] w_wake_sum;

  // Scrolling the pattern by 4 px per frame makes the wake appear to trail
  assign w_wake_sum = w_x + {3'b000, r_frame, 2'b00};
  assign w_wake     = (w_y >= 7'd64) && (w_x >= 7'd8) && (w_x <= 7'd71) &&
                      (w_wake_sum[3] == w_y[2]);
`else
  logic w_unused_frame;

  assign w_unused_frame = r_frame[1];
  assign w_wake         = 1'b0;
`endif

  always_comb begin
    boat_pixel   = 12'h000;
    in_boat_area = 1'b0;
    if (w_in_box) begin
      in_boat_area = 1'b1;
      if (w_mast)
        boat_pixel = c_GRAY;
      else if (w_flag)
        boat_pixel = c_RED;
      else if (w_window)
        boat_pixel = c_CYAN;
      else if (w_cabin || w_deck)
        boat_pixel = c_WHITE;
      else if (w_hull)
        boat_pixel = c_BROWN;
      else if (w_wake)
        boat_pixel = c_WHITE;
      else
        in_boat_area = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_boat_anim_sprite.sv
//==============================================================================
// Module   : tb_boat_anim_sprite
// Brief    : Directed bench for boat_anim_sprite; expected pixels go into a
//            queue and a monitor compares them against the DUT outputs.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_boat_anim_sprite;

  logic        clk;
  logic        rst;
  logic        slow_anim_tick;
  logic [9:0]  car_x;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic [11:0] boat_pixel;
  logic        in_boat_area;

  boat_anim_sprite dut (
    .clk            (clk),
    .rst            (rst),
    .slow_anim_tick (slow_anim_tick),
    .car_x          (car_x),
    .hCount         (hCount),
    .vCount         (vCount),
    .boat_pixel     (boat_pixel),
    .in_boat_area   (in_boat_area)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        area;
    logic [11:0] pix;
  } exp_t;

  exp_t q_exp[$];
  event chk_ev;
  int   n_vec;
  int   n_err;
  bit   done;

  // Monitor: consumes one expectation per presentation of the beam point
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      if (q_exp.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_underflow: got area=%0b pix=%h, required an expectation entry",
                 in_boat_area, boat_pixel);
      end else begin
        e = q_exp.pop_front();
        n_vec++;
        if (in_boat_area !== e.area || boat_pixel !== e.pix) begin
          n_err++;
          $display("FAIL %s: got area=%0b pix=%h, required area=%0b pix=%h",
                   e.name, in_boat_area, boat_pixel, e.area, e.pix);
        end
      end
    end
  end

  task automatic check(input string name, input int h, input int v,
                       input logic area, input logic [11:0] pix);
    exp_t e;
    hCount = h[9:0];
    vCount = v[9:0];
    e.name = name;
    e.area = area;
    e.pix  = pix;
    q_exp.push_back(e);
    #1;
    -> chk_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1 slow_anim_tick = 1'b1;
    @(posedge clk);
    #1 slow_anim_tick = 1'b0;
  endtask

  localparam logic [11:0] GRAY  = 12'h888;
  localparam logic [11:0] RED   = 12'hF00;
  localparam logic [11:0] CYAN  = 12'h09F;
  localparam logic [11:0] WHITE = 12'hFFF;
  localparam logic [11:0] BROWN = 12'h841;
  localparam logic [11:0] NONE  = 12'h000;

  initial begin
    n_vec = 0;
    n_err = 0;
    done  = 1'b0;
    rst = 1'b1;
    slow_anim_tick = 1'b0;
    car_x  = 10'd320;
    hCount = 10'd0;
    vCount = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flag", 330, 405, 1'b1, RED);
    rst = 1'b0;
    @(posedge clk);
    #1;

    check("mast", 320, 410, 1'b1, GRAY);
    check("left_out", 200, 410, 1'b0, NONE);
    check("flag_f0", 330, 405, 1'b1, RED);
    check("flag_edge_f0", 333, 405, 1'b1, RED);
    check("past_flag_f0", 334, 405, 1'b0, NONE);
    tick();
    check("flag_f1", 330, 405, 1'b0, NONE);
    check("flag_edge_f1", 329, 405, 1'b1, RED);
    tick();
    check("flag_f2", 330, 405, 1'b1, RED);

    check("window", 320, 428, 1'b1, CYAN);
    check("cabin", 305, 425, 1'b1, WHITE);
    check("deck", 281, 441, 1'b1, WHITE);
    check("hull", 290, 450, 1'b1, BROWN);
    check("hull_slope_out", 282, 462, 1'b0, NONE);
    check("hull_slope_in", 291, 462, 1'b1, BROWN);
    check("below_box", 320, 480, 1'b0, NONE);

`ifdef BOAT_WAKE_EN
    check("wake_f2", 290, 468, 1'b0, NONE);
    tick();
    tick();
    check("wake_f0", 290, 468, 1'b1, WHITE);
    check("flag_4ticks", 330, 405, 1'b1, RED);
    tick();
    check("wake_f1", 290, 468, 1'b1, WHITE);
`else
    check("wake_f2", 290, 468, 1'b0, NONE);
    tick();
    tick();
    check("wake_f0", 290, 468, 1'b0, NONE);
    check("flag_4ticks", 330, 405, 1'b1, RED);
    tick();
    check("wake_f1", 290, 468, 1'b0, NONE);
`endif
    check("flag_pre_rst", 330, 405, 1'b0, NONE);
    // Reset with no clock edge in between: frame must clear immediately
    rst = 1'b1;
    #1;
    check("async_rst", 330, 405, 1'b1, RED);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("after_rst_tick", 330, 405, 1'b0, NONE);

    car_x = 10'd20;
    check("clip_lx20", 0, 410, 1'b0, NONE);
    check("clip_mast18", 18, 410, 1'b1, GRAY);
    check("clip_mast21", 21, 410, 1'b1, GRAY);
    check("clip_nowrap", 1000, 410, 1'b0, NONE);
    check("clip_deck0", 0, 441, 1'b1, WHITE);

    repeat (2) @(posedge clk);
    done = 1'b1;
  end

  initial begin
    fork
      wait (done);
      #100000;
    join_any
    disable fork;
    if (!done) begin
      n_err++;
      $display("FAIL timeout: got no completion, required stimulus to finish");
    end
    if (q_exp.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d unchecked entries, required 0", q_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
